serial_word_packer: RTL and testbench
=====================================

// Module: serial_word_packer
// PURPOSE
// - Downstream consumer of the 3-tap XOR-feedback shift-register bit generator.
// - Collects its serial output bit stream into WIDTH-bit parallel words.
// - Buffers completed words in a 2-entry FIFO and presents them on a valid/ready interface.
// - Counts words dropped on backpressure, saturating.
// PARAMETERS
// - WIDTH      4   bits per assembled word (2..32)
// - MSB_FIRST  1   1: first received bit -> word_out[WIDTH-1]; 0: first bit -> word_out[0]
// PORTS
// - clk             in   1      single clock; all state updates on posedge
// - rst             in   1      synchronous reset, active-high
// - bit_in          in   1      serial data bit from the generator's out
// - bit_valid       in   1      bit_in is sampled this cycle
// - align           in   1      discard partial word; restart word boundary
// - word_out        out  WIDTH  FIFO head word
// - word_valid      out  1      FIFO non-empty
// - word_ready      in   1      consumer accepts word_out when word_valid
// - drop_count      out  8      dropped words, saturates at 8'hFF
// - word_parity     out  1      only with PACKER_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset: bit counter=0, assembly reg=0, FIFO empty, word_out=0, word_valid=0,
//   drop_count=0; word_parity=0. rst mid-word discards the partial word and FIFO contents.
// - Assembly: bit counter 0..WIDTH-1 advances only when bit_valid=1; bit k of the
//   word (k = arrival index) goes to bit WIDTH-1-k if MSB_FIRST, else bit k.
// - Completion: bit_valid=1 with counter==WIDTH-1 completes the word; counter wraps to 0;
//   word pushed into FIFO on that same edge; word_valid=1 the following cycle if FIFO was empty.
// - Latency: last bit sampled at edge N -> word_out/word_valid valid after edge N.
// - Handshake: pop when word_valid & word_ready. word_out/word_valid stable while
//   word_valid=1 & word_ready=0. word_ready with FIFO empty has no effect.
// - FIFO: 2 entries, in-order. Push+pop same cycle: both occur; occupancy unchanged.
// - Full: push with 2 entries and no pop -> new word dropped, FIFO unchanged,
//   drop_count+1 (held at 8'hFF). Push+pop while full -> no drop.
// - align=1: counter and assembly reg cleared. With bit_valid=1 same cycle,
//   that bit becomes arrival index 0 of the new word. align never completes
//   a word and never touches the FIFO or drop_count.
// - bit_valid=0: no state change in assembly path; FIFO still pops normally.
// CONFIGURATION
// - Macro PACKER_PARITY_EN.
// - Defined: word_parity port exists; each FIFO entry stores ^word alongside the
//   word; word_parity tracks word_out, is 0 when FIFO empty, follows the same stability rules.
// - Undefined: word_parity port and parity storage absent; all other behaviour identical.
// TESTING  (WIDTH=4 unless noted)
// - MSB_FIRST=1, bits 1,0,1,1 on 4 consecutive valid cycles, ready=1 -> word_out=4'hB,
//   word_valid=1 for exactly 1 cycle, starting the cycle after the 4th bit.
// - MSB_FIRST=0, same bits with bit_valid=0 gaps between them -> word_out=4'hD;
//   gaps do not advance the counter.
// - ready=0, stream 3 words 4'h1,4'h2,4'h3 -> FIFO holds 1,2; drop_count=1;
//   raise ready -> pops 4'h1 then 4'h2, then word_valid=0.
// - FIFO full, ready=1 on the cycle the 3rd word completes -> no drop, output order 1,2,3.
// - 2 bits then align=1 with bit_valid=1 bit=1, then 3 more bits 0,0,1 ->
//   single word 4'h9 (MSB_FIRST=1); partial word discarded.
// - Force 300 drops -> drop_count=8'hFF; rst=1 mid-word -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/serial_word_packer.sv
// Purpose: packs a serial bit stream into WIDTH-bit words behind a 2-entry FIFO with a saturating drop counter.
// Latency: the bit that completes a word is visible as word_out/word_valid right after the edge that samples it.
// Backpressure: the FIFO holds two words and the packer never stalls. A word completing into a full FIFO with no pop is dropped and counted.
// Optional feature: define PACKER_PARITY_EN to add the word_parity output, which carries ^word_out.
module serial_word_packer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             align,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [7:0]       drop_count
`ifdef PACKER_PARITY_EN
   ,
   output logic             word_parity
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] asm_reg;
   logic [CW-1:0]    cnt_base;
   logic [WIDTH-1:0] asm_base;
   logic [WIDTH-1:0] asm_next;
   logic [CW-1:0]    pos;
   logic             word_done;

   logic [WIDTH-1:0] mem [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;
   logic             pop;
   logic             full;
   logic             push_ok;
   logic             drop;

   // align restarts the word boundary before the current bit is placed, so a bit on an align cycle becomes arrival index 0
   always_comb begin
      cnt_base  = align ? '0 : bit_cnt;
      asm_base  = align ? '0 : asm_reg;
      pos       = MSB_FIRST ? (CW'(WIDTH - 1) - cnt_base) : cnt_base;
      asm_next  = asm_base;
      if (bit_valid) begin
         asm_next[pos] = bit_in;
      end
      word_done = bit_valid && (cnt_base == CW'(WIDTH - 1));
   end

   // bit counter and assembly register; a completed word leaves the assembly path and both restart from zero
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         asm_reg <= '0;
      end else if (word_done) begin
         bit_cnt <= '0;
         asm_reg <= '0;
      end else begin
         bit_cnt <= cnt_base + CW'(bit_valid);
         asm_reg <= asm_next;
      end
   end

   // a pop frees the slot in the same edge, so a completion into a full FIFO being drained is not a drop
   always_comb begin
      pop     = (count != 2'd0) && word_ready;
      full    = (count == 2'd2);
      push_ok = word_done && (!full || pop);
      drop    = word_done && full && !pop;
   end

   // FIFO storage and pointers; when full, wr_ptr equals rd_ptr, so a push with a simultaneous pop refills the slot being freed
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= asm_next;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push_ok && !pop) begin
            count <= count + 2'd1;
         end else if (!push_ok && pop) begin
            count <= count - 2'd1;
         end
      end
   end

   // saturating count of words lost to a full FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= 8'h00;
      end else if (drop && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'h01;
      end
   end

   // the head word is forced to zero while the FIFO is empty
   always_comb begin
      word_valid = (count != 2'd0);
      word_out   = word_valid ? mem[rd_ptr] : '0;
   end

`ifdef PACKER_PARITY_EN
   logic par_mem [2];

   // parity is stored beside each word so it moves through the FIFO in lockstep
   always_ff @(posedge clk) begin
      if (rst) begin
         par_mem[0] <= 1'b0;
         par_mem[1] <= 1'b0;
      end else if (push_ok) begin
         par_mem[wr_ptr] <= ^asm_next;
      end
   end

   // parity of the head word, zero while empty
   always_comb begin
      word_parity = word_valid ? par_mem[rd_ptr] : 1'b0;
   end
`endif

endmodule

// File: tb/tb_serial_word_packer.sv
// Purpose: bench for serial_word_packer. It drives both bit orders from one stimulus and compares them with a queue-based model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: word_ready is driven from the vector table, the hand sequences, and random draws; if PACKER_PARITY_EN is defined, word_parity is checked too.
module tb_serial_word_packer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       align = 1'b0;
   logic       word_ready = 1'b0;

   logic [3:0] wo_m, wo_l;
   logic       wv_m, wv_l;
   logic [7:0] dc_m, dc_l;
`ifdef PACKER_PARITY_EN
   logic       wp_m, wp_l;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_word_packer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .align(align),
      .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .drop_count(dc_m)
`ifdef PACKER_PARITY_EN
      , .word_parity(wp_m)
`endif
   );

   serial_word_packer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .align(align),
      .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .drop_count(dc_l)
`ifdef PACKER_PARITY_EN
      , .word_parity(wp_l)
`endif
   );

   // reference model: the bits of the partial word in arrival order, plus one word queue per bit order
   bit       cur[$];
   bit [3:0] qm[$];
   bit [3:0] ql[$];
   int       mdrop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit       pop;
      bit       done;
      bit [3:0] wm, wl;
      done = 1'b0;
      wm   = 4'h0;
      wl   = 4'h0;
      if (rst) begin
         cur.delete(); qm.delete(); ql.delete(); mdrop = 0;
         return;
      end
      pop = (qm.size() != 0) && word_ready;
      if (align) cur.delete();
      if (bit_valid) begin
         cur.push_back(bit_in);
         if (cur.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
               wm[3-k] = cur[k];
               wl[k]   = cur[k];
            end
            done = 1'b1;
            cur.delete();
         end
      end
      if (pop) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      if (done) begin
         if (qm.size() == 2) begin
            if (mdrop < 255) mdrop++;
         end else begin
            qm.push_back(wm);
            ql.push_back(wl);
         end
      end
   endtask

   // drive one cycle, advance the model on the edge, then compare both DUTs after the edge
   task automatic cycle(input logic r_s, input logic b, input logic v, input logic a, input logic rdy);
      rst = r_s; bit_in = b; bit_valid = v; align = a; word_ready = rdy;
      @(posedge clk);
      model_step();
      #1;
      chk("msb_word", 32'(wo_m), 32'((qm.size() != 0) ? qm[0] : 4'h0));
      chk("msb_valid", 32'(wv_m), 32'(qm.size() != 0));
      chk("msb_drop", 32'(dc_m), 32'(mdrop));
      chk("lsb_word", 32'(wo_l), 32'((ql.size() != 0) ? ql[0] : 4'h0));
      chk("lsb_valid", 32'(wv_l), 32'(ql.size() != 0));
      chk("lsb_drop", 32'(dc_l), 32'(mdrop));
`ifdef PACKER_PARITY_EN
      chk("msb_par", 32'(wp_m), 32'((qm.size() != 0) ? ^qm[0] : 1'b0));
      chk("lsb_par", 32'(wp_l), 32'((ql.size() != 0) ? ^ql[0] : 1'b0));
`endif
   endtask

   // vector table: inputs and hand-derived expected outputs of the MSB-first instance
   typedef struct {
      logic       r_s, b, v, a, rdy;
      logic [3:0] ew;
      logic       ev;
      logic [7:0] ed;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r_s, input logic b, input logic v, input logic a, input logic rdy,
                      input logic [3:0] ew, input logic ev, input logic [7:0] ed);
      vec_t t;
      t.r_s = r_s; t.b = b; t.v = v; t.a = a; t.rdy = rdy; t.ew = ew; t.ev = ev; t.ed = ed;
      vecs.push_back(t);
   endtask

   initial begin
      // bits 1,0,1,1 back to back: 4'hB for exactly one cycle
      add(1,0,0,0,1, 4'h0,0,0);
      add(0,1,1,0,1, 4'h0,0,0); add(0,0,1,0,1, 4'h0,0,0);
      add(0,1,1,0,1, 4'h0,0,0); add(0,1,1,0,1, 4'hB,1,0);
      add(0,0,0,0,1, 4'h0,0,0);
      // same bits with gaps; the ignored gap bits are set to 1
      add(0,1,1,0,1, 4'h0,0,0); add(0,1,0,0,1, 4'h0,0,0);
      add(0,0,1,0,1, 4'h0,0,0); add(0,1,0,0,1, 4'h0,0,0);
      add(0,1,1,0,1, 4'h0,0,0); add(0,1,0,0,1, 4'h0,0,0);
      add(0,1,1,0,1, 4'hB,1,0); add(0,0,0,0,1, 4'h0,0,0);
      // ready low, words 1,2,3: the third word is dropped, then the FIFO drains 1,2
      add(1,0,0,0,0, 4'h0,0,0);
      add(0,0,1,0,0, 4'h0,0,0); add(0,0,1,0,0, 4'h0,0,0);
      add(0,0,1,0,0, 4'h0,0,0); add(0,1,1,0,0, 4'h1,1,0);
      add(0,0,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,1,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,0,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,1,1,0,0, 4'h1,1,0); add(0,1,1,0,0, 4'h1,1,1);
      add(0,0,0,0,1, 4'h2,1,1); add(0,0,0,0,1, 4'h0,0,1);
      add(0,0,0,0,1, 4'h0,0,1);
      // full FIFO with ready on the completing cycle: no drop, order 1,2,3
      add(1,0,0,0,0, 4'h0,0,0);
      add(0,0,1,0,0, 4'h0,0,0); add(0,0,1,0,0, 4'h0,0,0);
      add(0,0,1,0,0, 4'h0,0,0); add(0,1,1,0,0, 4'h1,1,0);
      add(0,0,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,1,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,0,1,0,0, 4'h1,1,0); add(0,0,1,0,0, 4'h1,1,0);
      add(0,1,1,0,0, 4'h1,1,0); add(0,1,1,0,1, 4'h2,1,0);
      add(0,0,0,0,1, 4'h3,1,0); add(0,0,0,0,1, 4'h0,0,0);
      // partial 1,0 discarded by align carrying bit 1, then 0,0,1: 4'h9
      add(1,0,0,0,1, 4'h0,0,0);
      add(0,1,1,0,1, 4'h0,0,0); add(0,0,1,0,1, 4'h0,0,0);
      add(0,1,1,1,1, 4'h0,0,0); add(0,0,1,0,1, 4'h0,0,0);
      add(0,0,1,0,1, 4'h0,0,0); add(0,1,1,0,1, 4'h9,1,0);
      add(0,0,0,0,1, 4'h0,0,0);

      foreach (vecs[i]) begin
         cycle(vecs[i].r_s, vecs[i].b, vecs[i].v, vecs[i].a, vecs[i].rdy);
         chk($sformatf("vec%0d_word", i), 32'(wo_m), 32'(vecs[i].ew));
         chk($sformatf("vec%0d_valid", i), 32'(wv_m), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_drop", i), 32'(dc_m), 32'(vecs[i].ed));
      end

      // saturation: fill the FIFO with two words, then force 300 drops
      cycle(1, 0, 0, 0, 0);
      for (int w = 0; w < 302; w++) begin
         for (int k = 0; k < 4; k++) cycle(0, w[k], 1, 0, 0);
      end
      chk("sat_drop_msb", 32'(dc_m), 32'h0000_00FF);
      chk("sat_drop_lsb", 32'(dc_l), 32'h0000_00FF);
      chk("sat_valid", 32'(wv_m), 32'h1);

      // reset in the middle of a word clears every output on the next cycle
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      chk("rst_word", 32'(wo_m), 32'h0);
      chk("rst_valid", 32'(wv_m), 32'h0);
      chk("rst_drop", 32'(dc_m), 32'h0);
      // the partial word must be gone: four fresh bits 0,1,1,0 make 4'h6
      cycle(0, 0, 1, 0, 0); cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 1, 0, 0); cycle(0, 0, 1, 0, 0);
      chk("post_rst_word", 32'(wo_m), 32'h6);

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
